mul_shiftadd: RTL

MUL_SHIFTADD -- requirements
Module: mul_shiftadd

---
 rtl/mul_shiftadd.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mul_shiftadd.sv
`timescale 1ns/1ps
// mul_shiftadd: iterative shift-and-add multiplier, signed or unsigned.
//
// Operands are captured on the edge that accepts start. In signed mode they
// are reduced to magnitudes and the product sign is latched separately. One
// multiplier bit is consumed per RUN edge, LSB first. The result is available
// Y_WIDTH+1 edges after the capture edge, with the capture edge counted.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   start      operation request, accepted in IDLE or DONE
//   sign_mode  1 = two's-complement operands, 0 = unsigned
//   x          multiplicand (X_WIDTH bits)
//   y          multiplier (Y_WIDTH bits)
//   p          product magnitude (P_WIDTH bits), held until the next completion
//   s          product sign, 1 = negative; never set for a zero product
//   rdy        result valid; stays high in DONE until the next accepted start
//   busy       an operation is in progress
module mul_shiftadd #(
  parameter  int X_WIDTH = 3,
  parameter  int Y_WIDTH = 3,
  localparam int P_WIDTH = X_WIDTH + Y_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sign_mode,
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  output logic [P_WIDTH-1:0] p,
  output logic               s,
  output logic               rdy,
  output logic               busy
);

  localparam int            CW   = (Y_WIDTH > 1) ? $clog2(Y_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(Y_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [P_WIDTH-1:0]   mcand_q, mcand_d;  // multiplicand, pre-shifted by iteration index
  logic [Y_WIDTH-1:0]   mplr_q,  mplr_d;   // multiplier, shifted right so bit 0 is current
  logic                 sgn_q,   sgn_d;
  logic [P_WIDTH-1:0]   acc_q,   acc_d;
  logic [CW-1:0]        cnt_q,   cnt_d;
  logic [P_WIDTH-1:0]   p_q,     p_d;
  logic                 s_q,     s_d;
  logic                 rdy_q,   rdy_d;
  logic                 busy_q,  busy_d;

  logic [X_WIDTH-1:0]   xmag;
  logic [Y_WIDTH-1:0]   ymag;
  logic [P_WIDTH-1:0]   sum;

  // Negation of the most-negative value wraps back onto itself, which read
  // as unsigned is exactly 2^(W-1): the magnitude fits without overflow.
  always_comb begin
    xmag = (sign_mode && x[X_WIDTH-1]) ? -x : x;
    ymag = (sign_mode && y[Y_WIDTH-1]) ? -y : y;
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    sgn_d   = sgn_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    s_d     = s_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    sum     = acc_q + (mplr_q[0] ? mcand_q : '0);

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          mcand_d = {{Y_WIDTH{1'b0}}, xmag};
          mplr_d  = ymag;
          sgn_d   = sign_mode & (x[X_WIDTH-1] ^ y[Y_WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        // start is deliberately ignored here.
        acc_d   = sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          p_d     = sum;
          s_d     = sgn_q & (|sum);
          rdy_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplr_q  <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      s_q     <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      s_q     <= s_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign p    = p_q;
  assign s    = s_q;
  assign rdy  = rdy_q;
  assign busy = busy_q;

endmodule
